// File: rtl/berzerk_pkg.sv
// -----------------------------------------------------------------------------
// berzerk_pkg
// Shared definitions for the download/NVRAM port arbiter:
//   - arb_state_e : arbiter FSM states
//   - arb_out_t   : bundle of every registered arbiter output
//   - ROM_INDEX / NVRAM_INDEX : default ioctl_index values for ROM and NVRAM
//   - DN_AW / DN_DW : core download-port address and data widths
//   - is_hs_state() : true while the hiscore engine owns or is taking the port
// -----------------------------------------------------------------------------
package berzerk_pkg;

  localparam int DN_AW = 16;
  localparam int DN_DW = 8;

  localparam logic [7:0] ROM_INDEX   = 8'd0;
  localparam logic [7:0] NVRAM_INDEX = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_IOCTL      = 3'd1,
    ST_HS_PAUSE   = 3'd2,
    ST_HS_SETTLE  = 3'd3,
    ST_HS_GRANT   = 3'd4,
    ST_HS_RELEASE = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic             ioctl_wait;
    logic             pause_req;
    logic             hs_gnt;
    logic             busy;
    logic             dn_wr;
    logic             dn_nvram_wr;
    logic             dn_nvram;
    logic [DN_AW-1:0] dn_addr;
    logic [DN_DW-1:0] dn_data;
  } arb_out_t;

  // The HPS is stalled from the moment the hiscore engine starts acquiring
  // the port until the release cycle has completed.
  function automatic logic is_hs_state(arb_state_e s);
    return s inside {ST_HS_PAUSE, ST_HS_SETTLE, ST_HS_GRANT, ST_HS_RELEASE};
  endfunction

endpackage

// File: rtl/dn_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dn_port_arbiter_if
// The core's single download/NVRAM port.
//   dn_addr     : port address (ROM/NVRAM byte address)
//   dn_data     : write data
//   dn_wr       : ROM write strobe
//   dn_nvram_wr : NVRAM write strobe
//   dn_nvram    : port currently addresses NVRAM
// Modports: master = arbiter (drives the port), slave = game core.
// -----------------------------------------------------------------------------
interface dn_port_arbiter_if;
  import berzerk_pkg::*;

  logic [DN_AW-1:0] dn_addr;
  logic [DN_DW-1:0] dn_data;
  logic             dn_wr;
  logic             dn_nvram_wr;
  logic             dn_nvram;

  modport master (
    output dn_addr, dn_data, dn_wr, dn_nvram_wr, dn_nvram
  );

  modport slave (
    input dn_addr, dn_data, dn_wr, dn_nvram_wr, dn_nvram
  );
endinterface

// File: rtl/arb_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// Two counters used by the arbiter while acquiring the CPU pause.
//   clk_sys, reset : system clock, synchronous active-high reset
//   load_i         : load the settle counter with load_val_i
//   load_val_i     : settle reload value
//   dec_i          : decrement the settle counter (saturates at 0)
//   run_i          : timeout counter counts while high, clears while low
//   done_o         : settle counter is 0
//   expire_o       : timeout counter is all-ones
// -----------------------------------------------------------------------------
module arb_timer #(
  parameter int CNT_W     = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             run_i,
  output logic             done_o,
  output logic             expire_o
);

  logic [CNT_W-1:0]     cnt_q;
  logic [TIMEOUT_W-1:0] to_q;

  // NOTE: state is updated only with non-blocking assignments so that every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= '0;
    end else begin
      if (load_i) begin
        cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Clearing whenever the arbiter is outside the pause wait means each
      // entry into the wait starts a fresh timeout window.
      to_q <= run_i ? (to_q + TIMEOUT_W'(1)) : '0;
    end
  end

  assign done_o   = (cnt_q == '0);
  assign expire_o = &to_q;

endmodule

// File: rtl/dn_port_arbiter.sv
// -----------------------------------------------------------------------------
// dn_port_arbiter
// Owns the core's download/NVRAM port and shares it between the HPS ioctl
// stream and the hiscore NVRAM engine. The hiscore engine is only granted
// after the CPU has been paused and the pause has been stable for SETTLE
// cycles; the HPS is stalled while the engine holds or acquires the port.
//   clk_sys, reset  : system clock, synchronous active-high reset
//   ioctl_*         : HPS transfer (download, index, addr, dout, wr)
//   ioctl_wait      : stall to the HPS
//   hs_req          : hiscore level request, hs_address its port address
//   hs_gnt          : hiscore engine owns the port
//   hs_abort        : one-cycle pulse when the pause never arrived
//   paused          : CPU-paused status, pause_req its request
//   dn              : core download port (master side)
//   busy            : arbiter is not idle
// Every output is registered; outputs are decoded from the next state so
// they change on the same edge as the state.
// -----------------------------------------------------------------------------
module dn_port_arbiter #(
  parameter logic [7:0] ROM_INDEX   = berzerk_pkg::ROM_INDEX,
  parameter logic [7:0] NVRAM_INDEX = berzerk_pkg::NVRAM_INDEX,
  parameter int         HS_AW       = 10,
  parameter int         SETTLE      = 4,   // legal range 1..15
  parameter int         TIMEOUT_W   = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic              ioctl_wait,
  input  logic              hs_req,
  input  logic [HS_AW-1:0]  hs_address,
  output logic              hs_gnt,
  output logic              hs_abort,
  input  logic              paused,
  output logic              pause_req,
  dn_port_arbiter_if.master dn,
  output logic              busy
);

  import berzerk_pkg::arb_state_e, berzerk_pkg::arb_out_t,
         berzerk_pkg::DN_AW, berzerk_pkg::is_hs_state,
         berzerk_pkg::ST_IDLE, berzerk_pkg::ST_IOCTL,
         berzerk_pkg::ST_HS_PAUSE, berzerk_pkg::ST_HS_SETTLE,
         berzerk_pkg::ST_HS_GRANT, berzerk_pkg::ST_HS_RELEASE;

  // Loading SETTLE-1 on the paused edge places the grant SETTLE+1 cycles
  // after paused is first seen.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  arb_state_e state_q, state_d;
  arb_out_t   out_q, out_d;
  logic       hs_abort_q, hs_abort_d;
  logic       settle_done;
  logic       pause_expired;
  logic       index_rom;
  logic       index_nvram;
  logic       unused_addr_hi;

  assign index_rom      = (ioctl_index == ROM_INDEX);
  assign index_nvram    = (ioctl_index == NVRAM_INDEX);
  // The core port is 16 bits wide; the upper transfer address bits are dropped.
  assign unused_addr_hi = ^ioctl_addr[24:16];

  arb_timer #(
    .CNT_W     (4),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_i     ((state_q == ST_HS_PAUSE) && (state_d == ST_HS_SETTLE)),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (state_q == ST_HS_SETTLE),
    .run_i      (state_q == ST_HS_PAUSE),
    .done_o     (settle_done),
    .expire_o   (pause_expired)
  );

  // Next-state logic. A falling hs_req always wins inside the hiscore states
  // so the engine can withdraw at any point of the acquisition.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hs_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download)  state_d = ST_IOCTL;
        else if (hs_req)     state_d = ST_HS_PAUSE;
      end
      ST_IOCTL: begin
        if (!ioctl_download) state_d = ST_IDLE;
      end
      ST_HS_PAUSE: begin
        if (!hs_req) begin
          state_d = ST_HS_RELEASE;
        end else if (paused) begin
          state_d = ST_HS_SETTLE;
        end else if (pause_expired) begin
          state_d    = ST_HS_RELEASE;
          hs_abort_d = 1'b1;
        end
      end
      ST_HS_SETTLE: begin
        if (!hs_req)          state_d = ST_HS_RELEASE;
        else if (!paused)     state_d = ST_HS_PAUSE;
        else if (settle_done) state_d = ST_HS_GRANT;
      end
      ST_HS_GRANT: begin
        if (!hs_req)         state_d = ST_HS_RELEASE;
      end
      ST_HS_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the registered state.
  always_comb begin
    out_d            = '0;
    out_d.busy       = (state_d != ST_IDLE);
    out_d.ioctl_wait = is_hs_state(state_d);
    out_d.pause_req  = state_d inside {ST_HS_PAUSE, ST_HS_SETTLE, ST_HS_GRANT};
    out_d.hs_gnt     = (state_d == ST_HS_GRANT);
    case (state_d)
      ST_IOCTL: begin
        out_d.dn_addr     = ioctl_addr[15:0];
        out_d.dn_data     = ioctl_dout;
        out_d.dn_wr       = ioctl_wr & index_rom;
        out_d.dn_nvram_wr = ioctl_wr & index_nvram;
        out_d.dn_nvram    = index_nvram;
      end
      ST_HS_GRANT: begin
        // The hiscore engine only reads/writes NVRAM through its own path;
        // the strobes stay low and only the address is presented.
        out_d.dn_addr  = DN_AW'(hs_address);
        out_d.dn_nvram = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      hs_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      hs_abort_q <= hs_abort_d;
    end
  end

  assign ioctl_wait     = out_q.ioctl_wait;
  assign pause_req      = out_q.pause_req;
  assign hs_gnt         = out_q.hs_gnt;
  assign busy           = out_q.busy;
  assign hs_abort       = hs_abort_q;
  assign dn.dn_addr     = out_q.dn_addr;
  assign dn.dn_data     = out_q.dn_data;
  assign dn.dn_wr       = out_q.dn_wr;
  assign dn.dn_nvram_wr = out_q.dn_nvram_wr;
  assign dn.dn_nvram    = out_q.dn_nvram;

endmodule

// File: tb/tb_dn_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dn_port_arbiter
// Directed scenarios followed by a randomized run. A behavioural model tracks
// who owns the port (nobody, HPS, hiscore acquiring, hiscore granted,
// releasing) and counts consecutive paused cycles and pause-wait cycles to
// predict every output one cycle ahead.
// -----------------------------------------------------------------------------
module tb_dn_port_arbiter;

  localparam int SETTLE = 4;
  localparam int TW     = 4;
  localparam int HS_AW  = 10;

  // Model ownership modes.
  localparam int M_FREE  = 0;
  localparam int M_IOCTL = 1;
  localparam int M_ACQ   = 2;
  localparam int M_OWN   = 3;
  localparam int M_REL   = 4;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             ioctl_download;
  logic [7:0]       ioctl_index;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             ioctl_wr;
  logic             ioctl_wait;
  logic             hs_req;
  logic [HS_AW-1:0] hs_address;
  logic             hs_gnt;
  logic             hs_abort;
  logic             paused;
  logic             pause_req;
  logic             busy;

  dn_port_arbiter_if dn_bus ();

  dn_port_arbiter #(
    .ROM_INDEX   (8'd0),
    .NVRAM_INDEX (8'd4),
    .HS_AW       (HS_AW),
    .SETTLE      (SETTLE),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .hs_req         (hs_req),
    .hs_address     (hs_address),
    .hs_gnt         (hs_gnt),
    .hs_abort       (hs_abort),
    .paused         (paused),
    .pause_req      (pause_req),
    .dn             (dn_bus),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model state and predicted outputs.
  int          m_mode = M_FREE;
  int          m_run  = 0;
  int          m_wait = 0;
  logic [15:0] e_addr;
  logic [7:0]  e_data;
  logic        e_wr, e_nvwr, e_nvram, e_wait, e_preq, e_gnt, e_abort, e_busy;

  // Pause block stand-in: paused follows pause_req after pause_lat cycles.
  logic auto_pause  = 1'b0;
  logic glitch      = 1'b0;
  logic paused_last = 1'b0;
  int   pause_lat   = 3;
  int   pr_cnt      = 0;
  int   last_rise   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    e_abort = 1'b0;
    if (reset) begin
      m_mode = M_FREE;
      m_run  = 0;
      m_wait = 0;
    end else begin
      case (m_mode)
        M_FREE: begin
          if (ioctl_download) m_mode = M_IOCTL;
          else if (hs_req) begin
            m_mode = M_ACQ;
            m_run  = 0;
            m_wait = 0;
          end
        end
        M_IOCTL: if (!ioctl_download) m_mode = M_FREE;
        M_ACQ: begin
          if (!hs_req) m_mode = M_REL;
          else if (m_run == 0) begin
            if (paused) m_run = 1;
            else begin
              m_wait++;
              if (m_wait == (1 << TW)) begin
                m_mode  = M_REL;
                e_abort = 1'b1;
              end
            end
          end else if (!paused) begin
            m_run  = 0;
            m_wait = 0;
          end else begin
            m_run++;
            if (m_run == SETTLE + 1) m_mode = M_OWN;
          end
        end
        M_OWN:   if (!hs_req) m_mode = M_REL;
        default: m_mode = M_FREE;
      endcase
    end
    e_wait  = (m_mode >= M_ACQ);
    e_preq  = (m_mode == M_ACQ) || (m_mode == M_OWN);
    e_gnt   = (m_mode == M_OWN);
    e_busy  = (m_mode != M_FREE);
    e_addr  = 16'h0;
    e_data  = 8'h0;
    e_wr    = 1'b0;
    e_nvwr  = 1'b0;
    e_nvram = 1'b0;
    if (m_mode == M_IOCTL) begin
      e_addr  = ioctl_addr[15:0];
      e_data  = ioctl_dout;
      e_wr    = ioctl_wr && (ioctl_index == 8'd0);
      e_nvwr  = ioctl_wr && (ioctl_index == 8'd4);
      e_nvram = (ioctl_index == 8'd4);
    end else if (m_mode == M_OWN) begin
      e_addr  = 16'(hs_address);
      e_nvram = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("dn_addr",     32'(dn_bus.dn_addr),     32'(e_addr));
    check("dn_data",     32'(dn_bus.dn_data),     32'(e_data));
    check("dn_wr",       32'(dn_bus.dn_wr),       32'(e_wr));
    check("dn_nvram_wr", 32'(dn_bus.dn_nvram_wr), 32'(e_nvwr));
    check("dn_nvram",    32'(dn_bus.dn_nvram),    32'(e_nvram));
    check("ioctl_wait",  32'(ioctl_wait),         32'(e_wait));
    check("pause_req",   32'(pause_req),          32'(e_preq));
    check("hs_gnt",      32'(hs_gnt),             32'(e_gnt));
    check("hs_abort",    32'(hs_abort),           32'(e_abort));
    check("busy",        32'(busy),               32'(e_busy));
  endtask

  // One clock: settle inputs, predict, clock, compare 1 time unit later.
  task automatic tick();
    if (auto_pause) paused = e_preq && (pr_cnt >= pause_lat + 1) && !glitch;
    if (paused && !paused_last) last_rise = cyc;
    paused_last = paused;
    model_step();
    @(posedge clk_sys);
    #1;
    cyc++;
    compare_all();
    pr_cnt = e_preq ? pr_cnt + 1 : 0;
  endtask

  task automatic wait_gnt(output int at);
    at = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (hs_gnt === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int at;
    int n;
    int hs_hold;
    int dl_len;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_wr       = 1'b0;
    hs_req         = 1'b0;
    hs_address     = '0;
    paused         = 1'b0;
    #1;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // ROM load: upper address bits are dropped, write strobe one cycle later.
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_addr     = 25'h12345;
    ioctl_dout     = 8'hA5;
    ioctl_wr       = 1'b1;
    tick();
    check("rom_addr", 32'(dn_bus.dn_addr), 32'h2345);
    check("rom_data", 32'(dn_bus.dn_data), 32'hA5);
    check("rom_wr",   32'(dn_bus.dn_wr),   32'd1);
    check("rom_wait", 32'(ioctl_wait),     32'd0);
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    tick();
    tick();

    // Hiscore grant with paused arriving 3 cycles after pause_req.
    auto_pause = 1'b1;
    pause_lat  = 3;
    hs_req     = 1'b1;
    hs_address = 10'h3FF;
    tick();
    check("hs_preq_rise", 32'(pause_req),  32'd1);
    check("hs_wait_rise", 32'(ioctl_wait), 32'd1);
    wait_gnt(at);
    check("hs_gnt_latency", 32'(at - last_rise), 32'(SETTLE + 1));
    check("hs_addr",  32'(dn_bus.dn_addr),  32'h03FF);
    check("hs_nvram", 32'(dn_bus.dn_nvram), 32'd1);
    hs_req = 1'b0;
    tick();
    check("hs_gnt_fall",  32'(hs_gnt),     32'd0);
    check("hs_wait_hold", 32'(ioctl_wait), 32'd1);
    tick();
    check("hs_wait_fall", 32'(ioctl_wait), 32'd0);
    tick();

    // Simultaneous request: the HPS download wins.
    hs_req         = 1'b1;
    hs_address     = 10'h12A;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd4;
    ioctl_addr     = 25'h1ABCD;
    ioctl_dout     = 8'h3C;
    ioctl_wr       = 1'b1;
    tick();
    check("sim_nvram_wr", 32'(dn_bus.dn_nvram_wr), 32'd1);
    check("sim_rom_wr",   32'(dn_bus.dn_wr),       32'd0);
    check("sim_addr",     32'(dn_bus.dn_addr),     32'hABCD);
    check("sim_no_preq",  32'(pause_req),          32'd0);
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    tick();
    check("sim_idle", 32'(busy), 32'd0);
    tick();
    check("sim_hs_start", 32'(pause_req), 32'd1);
    wait_gnt(at);
    check("sim_gnt_latency", 32'(at - last_rise), 32'(SETTLE + 1));
    hs_req = 1'b0;
    tick();
    tick();

    // Pause timeout: paused never arrives.
    auto_pause = 1'b0;
    paused     = 1'b0;
    hs_req     = 1'b1;
    tick();
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (hs_abort === 1'b1) begin
        n = i;
        break;
      end
    end
    check("to_abort_latency", 32'(n), 32'(1 << TW));
    check("to_preq_fall",     32'(pause_req), 32'd0);
    hs_req = 1'b0;
    tick();
    check("to_abort_pulse", 32'(hs_abort), 32'd0);
    tick();

    // Reset while granted, then the request restarts the sequence.
    auto_pause = 1'b1;
    pause_lat  = 2;
    hs_req     = 1'b1;
    hs_address = 10'h155;
    wait_gnt(at);
    check("rst_pre_gnt", 32'(hs_gnt), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_gnt",   32'(hs_gnt),    32'd0);
    check("rst_preq",  32'(pause_req), 32'd0);
    check("rst_abort", 32'(hs_abort),  32'd0);
    wait_gnt(at);
    check("rst_regrant_latency", 32'(at - last_rise), 32'(SETTLE + 1));
    hs_req = 1'b0;
    tick();
    tick();

    // Settle glitch: paused drops during settle, grant follows its return.
    auto_pause = 1'b0;
    paused     = 1'b0;
    hs_req     = 1'b1;
    tick();
    tick();
    paused = 1'b1;
    tick();
    tick();
    paused = 1'b0;
    tick();
    check("gl_preq", 32'(pause_req), 32'd1);
    check("gl_gnt",  32'(hs_gnt),    32'd0);
    tick();
    paused = 1'b1;
    wait_gnt(at);
    check("gl_gnt_latency", 32'(at - last_rise), 32'(SETTLE + 1));
    hs_req = 1'b0;
    paused = 1'b0;
    tick();
    tick();

    // Randomized traffic from both masters, with pause latencies that
    // sometimes exceed the timeout and occasional glitches and resets.
    auto_pause = 1'b1;
    hs_hold    = 0;
    dl_len     = 0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (!hs_req) begin
        if ($urandom_range(0, 15) == 0) begin
          hs_req     = 1'b1;
          hs_address = HS_AW'($urandom);
          hs_hold    = $urandom_range(1, 12);
        end
      end else if (e_gnt) begin
        hs_address = HS_AW'($urandom);
        if (hs_hold == 0) hs_req = 1'b0;
        else hs_hold--;
      end else if (e_abort || ($urandom_range(0, 63) == 0)) begin
        hs_req = 1'b0;
      end
      if (!ioctl_download) begin
        ioctl_wr = 1'b0;
        if ($urandom_range(0, 23) == 0) begin
          ioctl_download = 1'b1;
          case ($urandom_range(0, 2))
            0:       ioctl_index = 8'd0;
            1:       ioctl_index = 8'd4;
            default: ioctl_index = 8'd2;
          endcase
          dl_len = $urandom_range(1, 20);
        end
      end else if (dl_len == 0) begin
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
      end else begin
        dl_len--;
        ioctl_wr   = !e_wait && ($urandom_range(0, 1) == 1);
        ioctl_addr = 25'($urandom);
        ioctl_dout = 8'($urandom);
      end
      if (!e_preq) pause_lat = $urandom_range(0, 20);
      glitch = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
